// File: rtl/mod_reduce_seq.sv
// Iterative shift-subtract divider: each RUN cycle removes the largest
// divisor multiple (d << k, k <= MAX_SHIFT) that still fits in the remainder.
module mod_reduce_seq #(
    parameter int WIDTH     = 16,
    parameter int MAX_SHIFT = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [5:0]       iter_count
);

    localparam int EXT_W = WIDTH + MAX_SHIFT;
    localparam int KW    = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [5:0]       iter_q, iter_d;
    logic             dbz_q, dbz_d;
    logic [KW-1:0]    k_sel;
    logic [EXT_W-1:0] sub_ext;

    // Compared at full extended width so a shifted divisor never wraps below r.
    function automatic logic [KW-1:0] largest_shift(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] d);
        logic [KW-1:0]    k_best;
        logic [EXT_W-1:0] d_ext;
        logic [EXT_W-1:0] r_ext;
        k_best = '0;
        r_ext  = EXT_W'(r);
        for (int k = 0; k <= MAX_SHIFT; k++) begin
            d_ext = EXT_W'(d) << k;
            if (d_ext <= r_ext) begin
                k_best = KW'(k);
            end
        end
        return k_best;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        iter_d  = iter_q;
        dbz_d   = dbz_q;
        k_sel   = largest_shift(r_q, d_q);
        sub_ext = EXT_W'(d_q) << k_sel;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = dividend;
                    d_d     = divisor;
                    q_d     = '0;
                    iter_d  = '0;
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (d_q == '0) begin
                    dbz_d   = 1'b1;
                    q_d     = '1;
                    state_d = DONE;
                end else if (r_q < d_q) begin
                    state_d = DONE;
                end else begin
                    // sub_ext <= r_q here, so the narrowing cast loses nothing.
                    r_d    = r_q - WIDTH'(sub_ext);
                    q_d    = q_q + (WIDTH'(1) << k_sel);
                    iter_d = sat_inc(iter_q);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            iter_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            iter_q  <= iter_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
    assign iter_count  = iter_q;

endmodule
